// File: rtl/cond_exec_stage.sv
// rtl/cond_exec_stage.sv - registered ARM condition evaluation with status register and debug counters
// Single-entry valid/ready stage: decides execute/squash one cycle after accept.
module cond_exec_stage #(
  parameter int          TAG_W    = 5,
  parameter int          CNT_W    = 16,
  parameter logic [3:0]  SR_RESET = 4'b0000,
  parameter bit          NV_NEVER = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_cond,
  input  logic             in_s,
  input  logic [3:0]       in_flags,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_exec,
  output logic [TAG_W-1:0] out_tag,
  input  logic             flush,
  input  logic             sr_wr_en,
  input  logic [3:0]       sr_wr_data,
  output logic [3:0]       sr,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] exec_cnt,
  output logic [CNT_W-1:0] squash_cnt
);

  logic             out_valid_q, out_valid_d;
  logic             out_exec_q, out_exec_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [3:0]       sr_q, sr_d;
  logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
  logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

  logic z, c, n, v;
  logic truth;
  logic accept;

  assign z = sr_q[3];
  assign c = sr_q[2];
  assign n = sr_q[1];
  assign v = sr_q[0];

  // Truth always comes from the registered flags, so a set-flags instruction
  // commits before its successor is evaluated.
  always_comb begin
    truth = 1'b0;
    case (in_cond)
      4'h0: truth = z;
      4'h1: truth = ~z;
      4'h2: truth = c;
      4'h3: truth = ~c;
      4'h4: truth = n;
      4'h5: truth = ~n;
      4'h6: truth = v;
      4'h7: truth = ~v;
      4'h8: truth = c & ~z;
      4'h9: truth = ~c | z;
      4'hA: truth = (n == v);
      4'hB: truth = (n != v);
      4'hC: truth = ~z & (n == v);
      4'hD: truth = z | (n != v);
      4'hE: truth = 1'b1;
      4'hF: truth = ~NV_NEVER;
    endcase
  end

  assign in_ready = (~out_valid_q | out_ready) & ~flush;
  assign accept   = in_valid & in_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_exec_d   = out_exec_q;
    out_tag_d    = out_tag_q;
    sr_d         = sr_q;
    exec_cnt_d   = exec_cnt_q;
    squash_cnt_d = squash_cnt_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_exec_d  = truth;
      out_tag_d   = in_tag;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Direct MSR write wins over an instruction's flag commit.
    if (sr_wr_en) begin
      sr_d = sr_wr_data;
    end else if (accept & truth & in_s) begin
      sr_d = in_flags;
    end

    if (clr_cnt) begin
      exec_cnt_d   = '0;
      squash_cnt_d = '0;
    end else if (accept) begin
      if (truth) begin
        if (~&exec_cnt_q) exec_cnt_d = exec_cnt_q + 1'b1;
      end else begin
        if (~&squash_cnt_q) squash_cnt_d = squash_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_exec_q   <= 1'b0;
      out_tag_q    <= '0;
      sr_q         <= SR_RESET;
      exec_cnt_q   <= '0;
      squash_cnt_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_exec_q   <= out_exec_d;
      out_tag_q    <= out_tag_d;
      sr_q         <= sr_d;
      exec_cnt_q   <= exec_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_exec   = out_exec_q;
  assign out_tag    = out_tag_q;
  assign sr         = sr_q;
  assign exec_cnt   = exec_cnt_q;
  assign squash_cnt = squash_cnt_q;

endmodule

// File: tb/tb_cond_exec_stage.sv
// tb/tb_cond_exec_stage.sv - bench for cond_exec_stage against a behavioural model
module tb_cond_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_cond = 4'h0;
  logic        in_s = 1'b0;
  logic [3:0]  in_flags = 4'h0;
  logic [4:0]  in_tag = 5'h0;
  logic        out_ready = 1'b1;
  logic        flush = 1'b0;
  logic        sr_wr_en = 1'b0;
  logic [3:0]  sr_wr_data = 4'h0;
  logic        clr_cnt = 1'b0;

  logic        in_ready, out_valid, out_exec;
  logic [4:0]  out_tag;
  logic [3:0]  sr;
  logic [15:0] exec_cnt, squash_cnt;

  logic        in_ready2, out_valid2, out_exec2;
  logic [4:0]  out_tag2;
  logic [3:0]  sr2;
  logic [1:0]  exec_cnt2, squash_cnt2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cond_exec_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_cond(in_cond), .in_s(in_s), .in_flags(in_flags), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_exec(out_exec),
    .out_tag(out_tag), .flush(flush), .sr_wr_en(sr_wr_en),
    .sr_wr_data(sr_wr_data), .sr(sr), .clr_cnt(clr_cnt),
    .exec_cnt(exec_cnt), .squash_cnt(squash_cnt)
  );

  cond_exec_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_cond(in_cond), .in_s(in_s), .in_flags(in_flags), .in_tag(in_tag),
    .out_valid(out_valid2), .out_ready(out_ready), .out_exec(out_exec2),
    .out_tag(out_tag2), .flush(flush), .sr_wr_en(sr_wr_en),
    .sr_wr_data(sr_wr_data), .sr(sr2), .clr_cnt(clr_cnt),
    .exec_cnt(exec_cnt2), .squash_cnt(squash_cnt2)
  );

  // ARM semantics: odd codes negate the even predicate below them; NV is special.
  function automatic logic cond_true(input logic [3:0] s, input logic [3:0] cc);
    logic fz, fc, fn, fv, base;
    fz = s[3]; fc = s[2]; fn = s[1]; fv = s[0];
    if (cc == 4'hF) return 1'b0;
    case (cc[3:1])
      3'd0: base = fz;
      3'd1: base = fc;
      3'd2: base = fn;
      3'd3: base = fv;
      3'd4: base = fc && !fz;
      3'd5: base = (fn == fv);
      3'd6: base = !fz && (fn == fv);
      default: base = 1'b1;
    endcase
    return cc[0] ? !base : base;
  endfunction

  function automatic int sat(input int val, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (val > mx) ? mx : val;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  logic       m_valid, m_exec;
  logic [4:0] m_tag;
  logic [3:0] m_sr;
  int         m_ec, m_sc;
  logic       m_acc, m_truth;

  assign m_acc   = in_valid && !flush && (!m_valid || out_ready);
  assign m_truth = cond_true(m_sr, in_cond);

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_exec <= 1'b0; m_tag <= '0; m_sr <= 4'b0000;
      m_ec <= 0; m_sc <= 0;
    end else begin
      if (m_acc) begin
        m_valid <= 1'b1; m_exec <= m_truth; m_tag <= in_tag;
      end else if (flush || out_ready) begin
        m_valid <= 1'b0;
      end
      if (sr_wr_en) m_sr <= sr_wr_data;
      else if (m_acc && m_truth && in_s) m_sr <= in_flags;
      if (clr_cnt) begin
        m_ec <= 0; m_sc <= 0;
      end else if (m_acc) begin
        if (m_truth) m_ec <= m_ec + 1;
        else m_sc <= m_sc + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("out_valid", out_valid, m_valid);
    chk("out_exec", out_exec, m_exec);
    chk("out_tag", out_tag, m_tag);
    chk("sr", sr, m_sr);
    chk("in_ready", in_ready, (!m_valid || out_ready) && !flush);
    chk("exec_cnt", exec_cnt, sat(m_ec, 16));
    chk("squash_cnt", squash_cnt, sat(m_sc, 16));
    chk("w2_out_valid", out_valid2, m_valid);
    chk("w2_out_exec", out_exec2, m_exec);
    chk("w2_sr", sr2, m_sr);
    chk("w2_exec_cnt", exec_cnt2, sat(m_ec, 2));
    chk("w2_squash_cnt", squash_cnt2, sat(m_sc, 2));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_s = 1'b0; flush = 1'b0; sr_wr_en = 1'b0; clr_cnt = 1'b0;
    out_ready = 1'b1;
  endtask

  int saved_e, saved_s;

  initial begin
    tick(); tick();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sr", sr, 0);
    chk("rst_exec_cnt", exec_cnt, 0);
    chk("rst_out_tag", out_tag, 0);
    rst_n = 1'b1;
    tick();

    in_valid = 1'b1; in_cond = 4'h0; in_tag = 5'd4;
    tick(); idle();
    @(negedge clk);
    chk("eq_first_valid", out_valid, 1);
    chk("eq_first_exec", out_exec, 0);
    chk("eq_first_squash", squash_cnt, 1);
    tick();

    in_valid = 1'b1; in_cond = 4'hE; in_s = 1'b1; in_flags = 4'b1000; in_tag = 5'd1;
    tick();
    in_cond = 4'h0; in_s = 1'b0; in_tag = 5'd2;
    @(negedge clk);
    chk("fwd_a_exec", out_exec, 1);
    chk("fwd_a_sr", sr, 4'b1000);
    tick(); idle();
    @(negedge clk);
    chk("fwd_b_exec", out_exec, 1);
    chk("fwd_b_tag", out_tag, 2);
    chk("fwd_exec_cnt", exec_cnt, 2);
    tick();

    sr_wr_en = 1'b1; sr_wr_data = 4'b0000;
    tick(); idle();
    in_valid = 1'b1; in_cond = 4'h0; in_s = 1'b1; in_flags = 4'b1111;
    tick(); idle();
    @(negedge clk);
    chk("sq_setflags_exec", out_exec, 0);
    chk("sq_setflags_sr", sr, 0);
    tick();

    for (int s = 0; s < 16; s++) begin
      sr_wr_en = 1'b1; sr_wr_data = 4'(s);
      tick(); idle();
      for (int cc = 0; cc < 16; cc++) begin
        in_valid = 1'b1; in_cond = 4'(cc); in_tag = 5'(cc);
        tick(); idle();
        @(negedge clk);
        chk("sweep_exec", out_exec, cond_true(4'(s), 4'(cc)));
        if (s == 12 && cc == 9) chk("ls_c1_z1", out_exec, 1);
        if (cc == 15) chk("nv_never", out_exec, 0);
      end
      tick();
    end

    idle(); tick();
    in_valid = 1'b1; in_cond = 4'hE; in_tag = 5'd7; out_ready = 1'b0;
    tick();
    in_tag = 5'd9;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_tag", out_tag, 7);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b1; in_tag = 5'd3; flush = 1'b1; out_ready = 1'b0;
    saved_e = m_ec; saved_s = m_sc;
    @(negedge clk);
    chk("drain_accept_tag", out_tag, 9);
    chk("drain_accept_valid", out_valid, 1);
    tick(); idle();
    @(negedge clk);
    chk("flush_valid", out_valid, 0);
    chk("flush_exec_cnt", exec_cnt, saved_e);
    chk("flush_squash_cnt", squash_cnt, saved_s);
    tick();

    in_valid = 1'b1; in_cond = 4'hE; in_s = 1'b1; in_flags = 4'b1000;
    sr_wr_en = 1'b1; sr_wr_data = 4'b0100;
    tick(); idle();
    @(negedge clk);
    chk("msr_priority_sr", sr, 4'b0100);
    chk("msr_priority_exec", out_exec, 1);
    tick();

    clr_cnt = 1'b1;
    tick(); idle();
    in_valid = 1'b1; in_cond = 4'hE;
    repeat (5) tick();
    idle();
    @(negedge clk);
    chk("sat_w2_exec", exec_cnt2, 3);
    chk("sat_w16_exec", exec_cnt, 5);
    in_valid = 1'b1; in_cond = 4'hE; clr_cnt = 1'b1;
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("clr_prio_w2", exec_cnt2, 0);
    chk("clr_prio_w16", exec_cnt, 0);
    chk("clr_prio_valid", out_valid, 1);
    tick();

    for (int i = 0; i < 3000; i++) begin
      rst_n      = ($urandom_range(0, 255) != 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 15) == 0);
      sr_wr_en   = ($urandom_range(0, 15) == 0);
      clr_cnt    = ($urandom_range(0, 127) == 0);
      in_s       = 1'($urandom);
      in_cond    = 4'($urandom);
      in_flags   = 4'($urandom);
      in_tag     = 5'($urandom);
      sr_wr_data = 4'($urandom);
      tick();
    end
    rst_n = 1'b1; idle();
    tick();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
